// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the rx_frame_loader deframer.
// The CHECK state exists only when RX_FRAME_CHECKSUM_EN is defined.
package rx_frame_pkg;

`ifdef RX_FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_LO   = 3'd1,
        W_HI   = 3'd2,
        H_LO   = 3'd3,
        H_HI   = 3'd4,
        PIXELS = 3'd5,
        CHECK  = 3'd6
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_LO   = 3'd1,
        W_HI   = 3'd2,
        H_LO   = 3'd3,
        H_HI   = 3'd4,
        PIXELS = 3'd5
    } rx_state_t;
`endif

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DIM     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

    // True when both dimensions are non-zero and within the accepted maxima.
    function automatic logic dims_valid(input logic [15:0] w, input logic [15:0] h,
                                        input int max_w, input int max_h);
        return (w != 16'd0) && (h != 16'd0) &&
               (int'(w) <= max_w) && (int'(h) <= max_h);
    endfunction

endpackage

// File: rtl/rx_frame_loader_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last byte and
// pulses expire on the cycle the count reaches TIMEOUT_CLKS-1 with no byte.
module rx_byte_timeout #(
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] count_reg;

    // A byte in the expiry cycle suppresses the expiry.
    assign expire = enable && !clear && (count_reg == LAST);

    // Counter reloads to zero on a byte, while disabled, or after expiring.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (clear || !enable || expire) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/rx_frame_loader.sv
// Frame deframer: SYNC, W_lo, W_hi, H_lo, H_hi, then W*H pixel bytes written
// to a frame buffer at linear addresses. Optional trailing checksum byte is
// enabled by the RX_FRAME_CHECKSUM_EN macro.
module rx_frame_loader
    import rx_frame_pkg::*;
#(
    parameter int         MAX_W        = 320,
    parameter int         MAX_H        = 240,
    parameter int         ADDR_W       = 17,
    parameter int         TIMEOUT_CLKS = 100000,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Wr_En,
    output logic [ADDR_W-1:0] o_Wr_Addr,
    output logic [7:0]        o_Wr_Data,
    output logic              o_Busy,
    output logic              o_Frame_Done,
    output logic              o_Frame_Err,
    output logic [1:0]        o_Err_Code,
    output logic [15:0]       o_Width,
    output logic [15:0]       o_Height
);

    rx_state_t         state_reg, state_next;
    logic [15:0]       width_reg, width_next;
    logic [15:0]       height_reg, height_next;
    logic [15:0]       col_reg, col_next;
    logic [15:0]       row_reg, row_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [7:0]        wr_data_reg, wr_data_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic [1:0]        err_code_reg, err_code_next;
`ifdef RX_FRAME_CHECKSUM_EN
    logic [7:0]        csum_reg, csum_next;
`endif

    logic              timeout_expire;
    logic [15:0]       height_full;

    rx_byte_timeout #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timeout (
        .clk    (i_Clock),
        .srst   (i_Reset),
        .clear  (i_Rx_DV),
        .enable (state_reg != IDLE),
        .expire (timeout_expire)
    );

    assign height_full = {i_Rx_Byte, height_reg[7:0]};

    // Next-state and datapath decode; pulses default low every cycle.
    always_comb begin
        state_next    = state_reg;
        width_next    = width_reg;
        height_next   = height_reg;
        col_next      = col_reg;
        row_next      = row_reg;
        addr_next     = addr_reg;
        wr_en_next    = 1'b0;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
        err_code_next = err_code_reg;
`ifdef RX_FRAME_CHECKSUM_EN
        csum_next     = csum_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    state_next    = W_LO;
                    err_code_next = ERR_NONE;
                    addr_next     = '0;
                    col_next      = '0;
                    row_next      = '0;
`ifdef RX_FRAME_CHECKSUM_EN
                    csum_next     = '0;
`endif
                end
            end
            W_LO: begin
                if (i_Rx_DV) begin
                    width_next[7:0] = i_Rx_Byte;
                    state_next      = W_HI;
                end
            end
            W_HI: begin
                if (i_Rx_DV) begin
                    width_next[15:8] = i_Rx_Byte;
                    state_next       = H_LO;
                end
            end
            H_LO: begin
                if (i_Rx_DV) begin
                    height_next[7:0] = i_Rx_Byte;
                    state_next       = H_HI;
                end
            end
            H_HI: begin
                if (i_Rx_DV) begin
                    height_next = height_full;
                    if (dims_valid(width_reg, height_full, MAX_W, MAX_H)) begin
                        state_next = PIXELS;
                    end else begin
                        err_next      = 1'b1;
                        err_code_next = ERR_DIM;
                        state_next    = IDLE;
                    end
                end
            end
            PIXELS: begin
                if (i_Rx_DV) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = addr_reg;
                    wr_data_next = i_Rx_Byte;
                    addr_next    = addr_reg + ADDR_W'(1);
`ifdef RX_FRAME_CHECKSUM_EN
                    csum_next    = csum_reg + i_Rx_Byte;
`endif
                    if (col_reg == width_reg - 16'd1) begin
                        col_next = '0;
                        row_next = row_reg + 16'd1;
                        if (row_reg == height_reg - 16'd1) begin
`ifdef RX_FRAME_CHECKSUM_EN
                            state_next = CHECK;
`else
                            done_next  = 1'b1;
                            state_next = IDLE;
`endif
                        end
                    end else begin
                        col_next = col_reg + 16'd1;
                    end
                end
            end
`ifdef RX_FRAME_CHECKSUM_EN
            CHECK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == csum_reg) begin
                        done_next = 1'b1;
                    end else begin
                        err_next      = 1'b1;
                        err_code_next = ERR_CSUM;
                    end
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase

        // Expiry only fires when no byte arrived, so it never collides with done.
        if (timeout_expire && (state_reg != IDLE)) begin
            err_next      = 1'b1;
            err_code_next = ERR_TIMEOUT;
            state_next    = IDLE;
        end
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_reg    <= IDLE;
            width_reg    <= '0;
            height_reg   <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            addr_reg     <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
`ifdef RX_FRAME_CHECKSUM_EN
            csum_reg     <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            width_reg    <= width_next;
            height_reg   <= height_next;
            col_reg      <= col_next;
            row_reg      <= row_next;
            addr_reg     <= addr_next;
            wr_en_reg    <= wr_en_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            err_code_reg <= err_code_next;
`ifdef RX_FRAME_CHECKSUM_EN
            csum_reg     <= csum_next;
`endif
        end
    end

    assign o_Wr_En      = wr_en_reg;
    assign o_Wr_Addr    = wr_addr_reg;
    assign o_Wr_Data    = wr_data_reg;
    assign o_Busy       = (state_reg != IDLE);
    assign o_Frame_Done = done_reg;
    assign o_Frame_Err  = err_reg;
    assign o_Err_Code   = err_code_reg;
    assign o_Width      = width_reg;
    assign o_Height     = height_reg;

endmodule

// File: tb/tb_rx_frame_loader.sv
// Directed testbench for rx_frame_loader (TIMEOUT_CLKS = 50).
// Build with +define+RX_FRAME_CHECKSUM_EN to exercise the checksum path.
module tb_rx_frame_loader;

    localparam int ADDR_W = 17;
    localparam int TMO    = 50;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_dv = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              frame_done;
    logic              frame_err;
    logic [1:0]        err_code;
    logic [15:0]       width;
    logic [15:0]       height;

    int n_checks = 0;
    int n_errors = 0;

    int wr_addr_q[$];
    int wr_data_q[$];
    int done_cnt = 0;
    int err_cnt = 0;
    int last_code = 0;
    int done_with_wr = 0;

    always #5 clk = ~clk;

    rx_frame_loader #(
        .MAX_W        (320),
        .MAX_H        (240),
        .ADDR_W       (ADDR_W),
        .TIMEOUT_CLKS (TMO),
        .SYNC_BYTE    (8'hAA)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Rx_DV      (rx_dv),
        .i_Rx_Byte    (rx_byte),
        .o_Wr_En      (wr_en),
        .o_Wr_Addr    (wr_addr),
        .o_Wr_Data    (wr_data),
        .o_Busy       (busy),
        .o_Frame_Done (frame_done),
        .o_Frame_Err  (frame_err),
        .o_Err_Code   (err_code),
        .o_Width      (width),
        .o_Height     (height)
    );

    // Log writes and completion pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_addr_q.push_back(int'(wr_addr));
            wr_data_q.push_back(int'(wr_data));
        end
        if (frame_done) begin
            done_cnt     = done_cnt + 1;
            done_with_wr = int'(wr_en);
        end
        if (frame_err) begin
            err_cnt   = err_cnt + 1;
            last_code = int'(err_code);
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt     = 0;
        err_cnt      = 0;
        last_code    = 0;
        done_with_wr = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic send_header(input int w, input int h);
        send_byte(8'hAA);
        send_byte(8'(w));
        send_byte(8'(w >> 8));
        send_byte(8'(h));
        send_byte(8'(h >> 8));
    endtask

    // Pixels are base, base+1, ...; the checksum byte is appended when enabled.
    task automatic send_frame(input int w, input int h, input int base);
        logic [7:0] sum;
        sum = 8'h00;
        send_header(w, h);
        for (int i = 0; i < w * h; i++) begin
            send_byte(8'(base + i));
            sum = sum + 8'(base + i);
        end
`ifdef RX_FRAME_CHECKSUM_EN
        send_byte(sum);
`endif
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        int seen;
        int bad_w[3];
        int bad_h[3];

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_wr_en", int'(wr_en), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(frame_done), 0);
        check_eq("rst_err", int'(frame_err), 0);
        check_eq("rst_code", int'(err_code), 0);
        check_eq("rst_width", int'(width), 0);
        check_eq("rst_addr", int'(wr_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        // 4x2 frame, pixels 0x10..0x17
        clear_log();
        send_frame(4, 2, 8'h10);
        settle();
        check_eq("f1_nwrites", wr_addr_q.size(), 8);
        for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
            check_eq($sformatf("f1_addr%0d", i), wr_addr_q[i], i);
            check_eq($sformatf("f1_data%0d", i), wr_data_q[i], 8'h10 + i);
        end
        check_eq("f1_done", done_cnt, 1);
        check_eq("f1_err", err_cnt, 0);
        check_eq("f1_width", int'(width), 4);
        check_eq("f1_height", int'(height), 2);
        check_eq("f1_busy", int'(busy), 0);
`ifdef RX_FRAME_CHECKSUM_EN
        check_eq("f1_done_wr", done_with_wr, 0);
`else
        check_eq("f1_done_wr", done_with_wr, 1);
`endif

        // Leading junk, then a 2x1 frame
        clear_log();
        send_byte(8'h00);
        send_byte(8'h55);
        send_frame(2, 1, 8'h33);
        settle();
        check_eq("junk_nwrites", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check_eq("junk_addr0", wr_addr_q[0], 0);
            check_eq("junk_data1", wr_data_q[1], 8'h34);
        end
        check_eq("junk_done", done_cnt, 1);

        // Bad dimensions
        bad_w = '{0, 321, 4};
        bad_h = '{2, 2, 241};
        for (int k = 0; k < 3; k++) begin
            clear_log();
            send_header(bad_w[k], bad_h[k]);
            settle();
            check_eq($sformatf("dim%0d_err", k), err_cnt, 1);
            check_eq($sformatf("dim%0d_code", k), last_code, 1);
            check_eq($sformatf("dim%0d_codereg", k), int'(err_code), 1);
            check_eq($sformatf("dim%0d_nwrites", k), wr_addr_q.size(), 0);
            check_eq($sformatf("dim%0d_busy", k), int'(busy), 0);
        end

        // Timeout after 2 pixels of a 2x2 frame
        clear_log();
        send_header(2, 2);
        send_byte(8'h01);
        send_byte(8'h02);
        n = 0;
        seen = 0;
        while (n < TMO + 20 && seen == 0) begin
            @(negedge clk);
            n++;
            if (frame_err) seen = 1;
        end
        check_eq("tmo_cycles", n, TMO);
        check_eq("tmo_code", int'(err_code), 2);
        settle();
        check_eq("tmo_busy", int'(busy), 0);
        check_eq("tmo_nwrites", wr_addr_q.size(), 2);
        check_eq("tmo_done", done_cnt, 0);

        // Byte landing in the expiry cycle wins
        clear_log();
        send_header(2, 2);
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (TMO - 2) @(negedge clk);
        send_byte(8'h03);
        send_byte(8'h04);
`ifdef RX_FRAME_CHECKSUM_EN
        send_byte(8'h0A);
`endif
        settle();
        check_eq("race_err", err_cnt, 0);
        check_eq("race_done", done_cnt, 1);
        check_eq("race_nwrites", wr_addr_q.size(), 4);

`ifdef RX_FRAME_CHECKSUM_EN
        // Checksum match and mismatch
        clear_log();
        send_header(2, 1);
        send_byte(8'hF0);
        send_byte(8'h20);
        send_byte(8'h10);
        settle();
        check_eq("csum_ok_done", done_cnt, 1);
        check_eq("csum_ok_err", err_cnt, 0);
        clear_log();
        send_header(2, 1);
        send_byte(8'hF0);
        send_byte(8'h20);
        send_byte(8'h11);
        settle();
        check_eq("csum_bad_done", done_cnt, 0);
        check_eq("csum_bad_err", err_cnt, 1);
        check_eq("csum_bad_code", last_code, 3);
`endif

        // Reset during PIXELS, then a fresh frame
        clear_log();
        send_header(4, 2);
        send_byte(8'h21);
        send_byte(8'h22);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_wr_en", int'(wr_en), 0);
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_err", int'(frame_err), 0);
        check_eq("mid_rst_addr", int'(wr_addr), 0);
        check_eq("mid_rst_width", int'(width), 0);
        clear_log();
        send_frame(2, 1, 8'h40);
        settle();
        check_eq("post_rst_nwrites", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check_eq("post_rst_addr0", wr_addr_q[0], 0);
            check_eq("post_rst_data0", wr_data_q[0], 8'h40);
        end
        check_eq("post_rst_done", done_cnt, 1);
        check_eq("post_rst_err", err_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard bound on run time in case a wait never resolves.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rx_frame_loader.md
# rx_frame_loader

Frame deframer that sits directly downstream of the UART byte receiver in the edge-detector datapath. It consumes the receiver's one-cycle byte-valid strobe and byte. It parses a small header carrying the image width and height, then writes each following pixel byte to the frame buffer at a linear address. It signals completion or error to the edge-detector controller.

## Interface
- `MAX_W`, 320, largest accepted image width in pixels
- `MAX_H`, 240, largest accepted image height in pixels
- `ADDR_W`, 17, frame-buffer address width; must satisfy 2^ADDR_W ≥ MAX_W·MAX_H
- `TIMEOUT_CLKS`, 100000, maximum allowed clock cycles between bytes once a frame has started
- `SYNC_BYTE`, 8'hAA, frame start marker
- `i_Clock`  in  1  system clock
- `i_Reset`  in  1  synchronous, active-high reset
- `i_Rx_DV`  in  1  one-cycle byte-valid strobe from the UART receiver
- `i_Rx_Byte`  in  8  received byte; valid only while `i_Rx_DV`=1
- `o_Wr_En`  out  1  frame-buffer write strobe
- `o_Wr_Addr`  out  ADDR_W  frame-buffer write address
- `o_Wr_Data`  out  8  pixel byte to write
- `o_Busy`  out  1  high in every state except IDLE
- `o_Frame_Done`  out  1  one-cycle pulse when a frame has been accepted
- `o_Frame_Err`  out  1  one-cycle pulse when a frame is aborted
- `o_Err_Code`  out  2  abort reason: 0 none, 1 bad dimensions, 2 timeout, 3 checksum
- `o_Width`  out  16  latched width; valid from `o_Frame_Done` until the next sync byte
- `o_Height`  out  16  latched height; same validity as `o_Width`

## Operation
- Byte format: SYNC, W_lo, W_hi, H_lo, H_hi, then W·H pixel bytes in row-major order.
  - When `CHECKSUM_EN` is defined, one checksum byte follows the pixels.
- States: IDLE → W_LO → W_HI → H_LO → H_HI → PIXELS → (CHECK) → IDLE. The state advances only on `i_Rx_DV`.
- IDLE:
  - Bytes other than SYNC_BYTE are discarded.
  - SYNC_BYTE moves to W_LO and clears `o_Err_Code`, the address counter, the column/row counters and the checksum accumulator.
- H_HI, on the byte completing the height, checks the dimensions:
  - A width or height of 0, width > MAX_W or height > MAX_H → `o_Frame_Err` pulse, code 1, return to IDLE.
  - Otherwise → PIXELS.
- PIXELS, per byte:
  - Write the byte at the current address, then increment the address.
  - Column counter counts 0..W-1; on wrap to 0 the row counter increments.
  - Address is a plain linear counter; no multiplier is used.
- The last pixel is the byte at column W-1, row H-1:
  - Without `CHECKSUM_EN`: `o_Frame_Done` pulse, → IDLE.
  - With `CHECKSUM_EN`: → CHECK.
- Timeout counter:
  - Counts in every non-IDLE state and clears on every `i_Rx_DV`.
  - When it reaches TIMEOUT_CLKS-1 without a byte: `o_Frame_Err` pulse, code 2, → IDLE.
- Simultaneous events: a byte arriving in the expiry cycle wins; no timeout is taken.
- Pixels already written before an abort are left in memory; the block never clears the frame buffer.
- `o_Done` and `o_Err` are never asserted in the same cycle.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - All counters 0.
- Write latency:
  - `o_Wr_En`, `o_Wr_Addr` and `o_Wr_Data` are registered.
  - `o_Wr_En` is high for exactly one cycle, the cycle after the accepting `i_Rx_DV`.
- Completion latency:
  - `o_Frame_Done` and `o_Frame_Err` assert the cycle after the deciding byte or the timeout expiry.
  - `o_Frame_Done` coincides with the final `o_Wr_En` when there is no checksum.
- Back-to-back frames:
  - A SYNC_BYTE may arrive on the very next `i_Rx_DV` after completion.
  - The upstream receiver guarantees at least one idle cycle between strobes.
- Reset mid-frame aborts immediately:
  - No `o_Frame_Err` pulse is produced.
  - `o_Wr_En` is 0 in the cycle after reset.

## Configuration
- `RX_FRAME_CHECKSUM_EN` defined:
  - The CHECK state exists.
  - An 8-bit accumulator sums the pixel bytes mod 256; header bytes are excluded.
  - The received checksum byte is compared against the accumulator:
    - match → `o_Frame_Done`;
    - mismatch → `o_Frame_Err`, code 3.
  - The CHECK state is subject to the timeout.
- Undefined:
  - No accumulator and no CHECK state.
  - Error code 3 never occurs.

## Structure
- Package `rx_frame_pkg`:
  - state enum;
  - error-code constants `ERR_NONE`, `ERR_DIM`, `ERR_TIMEOUT`, `ERR_CSUM`;
  - default sync byte.
- Sub-module `rx_byte_timeout`:
  - loadable counter parameterised by TIMEOUT_CLKS;
  - inputs clear and enable, output expire pulse.

## Test plan
- 4×2 frame, pixels 0x10..0x17 → eight writes at addresses 0..7 carrying data 0x10..0x17, `o_Frame_Done` once, `o_Width`=4, `o_Height`=2.
- Bytes 0x00, 0x55, then a valid frame → the leading bytes are ignored, and the frame is accepted normally.
- Header width 0 / width MAX_W+1 / height MAX_H+1 → `o_Frame_Err` with code 1, no writes, then back in IDLE.
- 2×2 frame stalled after 2 pixels for TIMEOUT_CLKS cycles (TIMEOUT_CLKS=50 in the bench) → code 2 after exactly 50 idle cycles. A byte landing on cycle 49 → no error.
- With `RX_FRAME_CHECKSUM_EN`, 2×1 frame with pixels 0xF0, 0x20:
  - checksum 0x10 → done;
  - checksum 0x11 → code 3.
- `i_Reset` asserted during PIXELS → all outputs 0 the next cycle; a following valid frame starts at address 0.
